seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 100_000: clk cycles per digit slot; SCAN_DIV >= 4.
REQ-003 Parameter BLANK_CYC, default 1_000: ghost-blanking cycles at the start of each slot; BLANK_CYC < SCAN_DIV.
REQ-004 Parameter BLINK_FRAMES, default 250: full frames per blink half-period; >= 1.
REQ-005 clk  input  1  system clock; the block's only clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, with digit 0 the rightmost.
REQ-008 dp  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-009 blank_mask  input  NUM_DIGITS  force digit dark, active-high.
REQ-010 blink_mask  input  NUM_DIGITS  digit dark during the blink-off phase, active-high.
REQ-011 lz_en  input  1  leading-zero suppression enable.
REQ-012 sm_wei  output  NUM_DIGITS  digit select, active-low, at most one bit low.
REQ-013 sm_duan  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 sm_dp  output  1  decimal-point segment, active-low.
REQ-015 frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-016 tick_cnt SHALL count 0..SCAN_DIV-1 and wrap; idx SHALL advance by 1 on the edge where tick_cnt==SCAN_DIV-1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 On the edge where idx wraps to 0, the block SHALL copy data, dp, blank_mask, blink_mask and lz_en into shadow registers; display SHALL use only shadow values, so no frame shows mixed old and new data.
REQ-018 frame_start SHALL be high for exactly the one cycle following each shadow load.
REQ-019 Frame counter SHALL increment at each shadow load; at count BLINK_FRAMES-1 it SHALL clear and toggle blink_on.
REQ-020 Digit idx is dark when any of these holds: tick_cnt < BLANK_CYC; shadow blank_mask[idx]; shadow blink_mask[idx] and blink_on==0; LZ-suppressed.
REQ-021 LZ-suppressed: shadow lz_en=1, idx != 0, and all shadow nibbles idx..NUM_DIGITS-1 equal 0; digit 0 is never LZ-suppressed.
REQ-022 For a dark digit: sm_wei all ones, sm_duan 7'h7F, sm_dp 1; otherwise sm_wei[idx]=0 and all other bits 1, sm_duan = decode(nibble idx), sm_dp = ~dp[idx].
REQ-023 Decode (hex, 7-bit) 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-024 sm_wei, sm_duan and sm_dp SHALL be registered, with a latency of exactly one clk from the idx/tick_cnt/shadow state they represent.
REQ-025 Input changes between shadow loads SHALL have no visible effect until the next load.

Reset
REQ-026 While rst_n=0: tick_cnt=0, idx=0, frame counter=0, blink_on=1, all shadows 0, sm_wei all ones, sm_duan 7'h7F, sm_dp=1, frame_start=0.
REQ-027 Reset SHALL take effect immediately and asynchronously, including mid-slot; release SHALL be synchronised internally with a 2-flop synchroniser, and counting starts on the first edge after synchronised release.
REQ-028 Shadows SHALL first load at the first idx wrap after reset; the display SHALL show digit 0 with shadow value 0 ("0" segments 40) until then.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-029 data=16'h12AF, masks 0, lz_en=0 -> in successive slots sm_wei 1110/1101/1011/0111 with sm_duan 0E/08/24/79; all-ones anodes for the first 2 cycles of each slot; frame_start every 32 cycles.
REQ-030 Change data from 16'h1234 to 16'h5678 mid-frame -> the remaining digits of that frame still show 1234 encodings; 5678 appears only after the next frame_start.
REQ-031 data=16'h0050, lz_en=1 -> digits 3 and 2 dark; digit 1 shows 12 ("5"); digit 0 shows 40. data=16'h0000 -> only digit 0 lit (40).
REQ-032 blink_mask=4'b0001, dp=4'b0100 -> digit 0 lit for 2 frames and dark for 2 frames, repeating; sm_dp=0 only during digit 2's lit cycles.
REQ-033 Assert rst_n=0 mid-slot while digit 2 is lit -> same cycle sm_wei=1111, sm_duan=7F, frame_start=0; after release, the scan restarts at idx 0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Display-controller bus: per-digit content and masks in, multiplexed segment drive out.
// The master modport drives content and masks; the slave (controller) drives the segment lines.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   sm_wei;
  logic [6:0]              sm_duan;
  logic                    sm_dp;
  logic                    frame_start;

  modport master (
    output data, dp, blank_mask, blink_mask, lz_en,
    input  sm_wei, sm_duan, sm_dp, frame_start
  );

  modport slave (
    input  data, dp, blank_mask, blink_mask, lz_en,
    output sm_wei, sm_duan, sm_dp, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: frame-coherent shadows, ghost blanking, blink and LZ suppression.
// Outputs are registered 1 clk behind the scan state; free-running, no backpressure.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYC    = 1_000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

  logic [1:0]                  rst_sync_q, rst_sync_d;
  logic [TW-1:0]               tick_q, tick_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [FW-1:0]               frm_q, frm_d;
  logic                        blink_on_q, blink_on_d;
  logic [NUM_DIGITS-1:0][3:0]  sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]       sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]       sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]       sh_blink_q, sh_blink_d;
  logic                        sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0]       wei_q, wei_d;
  logic [6:0]                  duan_q, duan_d;
  logic                        dp_q, dp_d;
  logic                        fs_q, fs_d;

  logic                        run, slot_end, frame_end;
  logic [NUM_DIGITS-1:0]       lz_zero;
  logic                        zero_acc, lz_sup, dark;
  logic [3:0]                  cur_nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Scan state is held at reset values until the synchronised release reaches rst_sync_q[1].
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    run        = rst_sync_q[1];
    slot_end   = (tick_q == TICK_LAST);
    frame_end  = slot_end && (idx_q == IDX_LAST);

    tick_d     = tick_q;
    idx_d      = idx_q;
    frm_d      = frm_q;
    blink_on_d = blink_on_q;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_blink_d = sh_blink_q;
    sh_lz_d    = sh_lz_q;

    if (run) begin
      tick_d = slot_end ? '0 : tick_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frame_end) begin
        sh_data_d  = bus.data;
        sh_dp_d    = bus.dp;
        sh_blank_d = bus.blank_mask;
        sh_blink_d = bus.blink_mask;
        sh_lz_d    = bus.lz_en;
        if (frm_q == FRM_LAST) begin
          frm_d      = '0;
          blink_on_d = ~blink_on_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
    end
    fs_d = run && frame_end;
  end

  // lz_zero[i] is set when shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_acc = 1'b1;
    lz_zero  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc   = zero_acc & (sh_data_q[i] == 4'h0);
      lz_zero[i] = zero_acc;
    end
    cur_nib = sh_data_q[idx_q];
    lz_sup  = sh_lz_q && (idx_q != '0) && lz_zero[idx_q];
    dark    = (tick_q < TICK_BLANK) || sh_blank_q[idx_q] ||
              (sh_blink_q[idx_q] && !blink_on_q) || lz_sup;
    if (dark) begin
      wei_d  = '1;
      duan_d = 7'h7F;
      dp_d   = 1'b1;
    end else begin
      wei_d  = ~(NUM_DIGITS'(1) << idx_q);
      duan_d = seg_decode(cur_nib);
      dp_d   = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
      tick_q     <= '0;
      idx_q      <= '0;
      frm_q      <= '0;
      blink_on_q <= 1'b1;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_blink_q <= '0;
      sh_lz_q    <= 1'b0;
      wei_q      <= '1;
      duan_q     <= 7'h7F;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      frm_q      <= frm_d;
      blink_on_q <= blink_on_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_blink_q <= sh_blink_d;
      sh_lz_q    <= sh_lz_d;
      wei_q      <= wei_d;
      duan_q     <= duan_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.sm_wei      = wei_q;
  assign bus.sm_duan     = duan_q;
  assign bus.sm_dp       = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle comparison against an arithmetic frame/slot model,
// plus directed window counts for frame rate, blink, leading-zero and restart timing.
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FR = SD * ND;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: m_n counts advancing cycles since release; slot, digit and frame follow by division.
  int            m_n;
  int            m_rel;
  logic [15:0]   m_data;
  logic [ND-1:0] m_dp, m_blank, m_blink;
  logic          m_lz;
  logic          m_fs_last;

  int fs_cnt, lit_cnt, d0_lit, dp_low;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_rel = 0; m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
    m_fs_last = 1'b0;
  endtask

  function automatic void model_out(output logic [ND-1:0] w, output logic [6:0] s, output logic d);
    int          tick, idx, frame;
    logic        bon, dark;
    logic [15:0] up;
    tick  = m_n % SD;
    idx   = (m_n / SD) % ND;
    frame = m_n / FR;
    bon   = ((frame / BF) % 2) == 0;
    up    = m_data >> (4 * idx);
    dark  = (tick < BC) || m_blank[idx] || (m_blink[idx] && !bon) ||
            (m_lz && idx != 0 && up == 16'h0);
    if (dark) begin
      w = '1; s = 7'h7F; d = 1'b1;
    end else begin
      w = '1; w[idx] = 1'b0;
      s = SEG_TAB[up[3:0]];
      d = ~m_dp[idx];
    end
  endfunction

  task automatic step(input bit chk);
    logic [ND-1:0] e_wei;
    logic [6:0]    e_duan;
    logic          e_dp, e_fs;
    @(posedge clk);
    model_out(e_wei, e_duan, e_dp);
    e_fs = 1'b0;
    if (!rst_n) begin
      m_rel = 0;
    end else begin
      if (m_rel < 3) m_rel++;
      if (m_rel >= 3) begin
        if (m_n % FR == FR - 1) begin
          m_data = bus.data; m_dp = bus.dp; m_blank = bus.blank_mask;
          m_blink = bus.blink_mask; m_lz = bus.lz_en;
          e_fs = 1'b1;
        end
        m_n++;
      end
    end
    m_fs_last = e_fs;
    #1;
    if (chk) begin
      check_eq("sm_wei", 32'(bus.sm_wei), 32'(e_wei));
      check_eq("sm_duan", 32'(bus.sm_duan), 32'(e_duan));
      check_eq("sm_dp", 32'(bus.sm_dp), 32'(e_dp));
      check_eq("frame_start", 32'(bus.frame_start), 32'(e_fs));
    end
    if (bus.frame_start) fs_cnt++;
    if (bus.sm_wei != '1) lit_cnt++;
    if (bus.sm_wei == 4'b1110) d0_lit++;
    if (!bus.sm_dp) dp_low++;
  endtask

  task automatic wait_load();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      step(1);
      got = m_fs_last;
    end
    if (!got) check_eq("load_wait", 32'(got), 32'd1);
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [ND-1:0] p, input logic [ND-1:0] bl,
                            input logic [ND-1:0] bk, input logic lz);
    bus.data = d; bus.dp = p; bus.blank_mask = bl; bus.blink_mask = bk; bus.lz_en = lz;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    set_inputs(16'h0, '0, '0, '0, 1'b0);
    model_reset();
    #12;
    check_eq("rst_wei", 32'(bus.sm_wei), 32'hF);
    check_eq("rst_duan", 32'(bus.sm_duan), 32'h7F);
    check_eq("rst_dp", 32'(bus.sm_dp), 32'h1);
    check_eq("rst_fs", 32'(bus.frame_start), 32'h0);
    step(1); step(1);
    rst_n = 1'b1;

    // Basic scan of 12AF and frame rate.
    set_inputs(16'h12AF, '0, '0, '0, 1'b0);
    repeat (40) step(1);
    fs_cnt = 0;
    repeat (96) step(1);
    check_eq("fs_per_96cyc", 32'(fs_cnt), 32'd3);

    // Mid-frame data change must wait for the next load.
    bus.data = 16'h1234;
    wait_load();
    repeat (12) step(1);
    bus.data = 16'h5678;
    repeat (64) step(1);

    // Leading-zero suppression.
    set_inputs(16'h0050, '0, '0, '0, 1'b1);
    wait_load();
    lit_cnt = 0;
    repeat (FR) step(1);
    check_eq("lz_lit_0050", 32'(lit_cnt), 32'd12);
    bus.data = 16'h0000;
    wait_load();
    lit_cnt = 0; d0_lit = 0;
    repeat (FR) step(1);
    check_eq("lz_lit_0000", 32'(lit_cnt), 32'd6);
    check_eq("lz_d0_0000", 32'(d0_lit), 32'd6);

    // Blink on digit 0, decimal point on digit 2.
    set_inputs(16'h1234, 4'b0100, '0, 4'b0001, 1'b0);
    wait_load();
    d0_lit = 0; dp_low = 0;
    repeat (4 * FR) step(1);
    check_eq("blink_d0_lit", 32'(d0_lit), 32'd12);
    check_eq("dp_low_cyc", 32'(dp_low), 32'd24);

    // Random traffic.
    repeat (1600) begin
      if ($urandom_range(7, 0) == 0) begin
        set_inputs(16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom),
                   4'($urandom), 1'($urandom));
      end
      step(1);
    end

    // Asynchronous reset while digit 2 is lit.
    set_inputs(16'h1234, '0, '0, '0, 1'b0);
    wait_load();
    for (int k = 0; k < 64; k++) begin
      step(1);
      if (((m_n - 1) / SD) % ND == 2 && (m_n - 1) % SD >= BC) break;
    end
    check_eq("pre_rst_wei", 32'(bus.sm_wei), 32'b1011);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_wei", 32'(bus.sm_wei), 32'hF);
    check_eq("mid_rst_duan", 32'(bus.sm_duan), 32'h7F);
    check_eq("mid_rst_dp", 32'(bus.sm_dp), 32'h1);
    check_eq("mid_rst_fs", 32'(bus.frame_start), 32'h0);
    repeat (3) step(1);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (bus.sm_wei == 4'b1110) begin
        lat = k;
        break;
      end
    end
    check_eq("restart_d0_latency", 32'(lat), 32'd5);
    repeat (64) step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
